addr_mode_seq: RTL
==================

# addr_mode_seq

Multi-cycle operand sequencer for the 16-bit CPU, placed between instruction decode and register-file writeback. It resolves register, immediate, direct and (optionally) indirect addressing modes by sequencing register-file reads, instruction-word fetches and data-memory reads. It then presents one writeback beat per instruction. It is parametrised in data width, register-address width and accumulator location.

## Interface
- DATA_W, 16, data and memory-address width
- RADDR_W, 3, register-file address width
- ACC_ADDR, 0, register index written by LDA
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request to execute `opcode`; accepted only in IDLE
- opcode  in  4  MOV=1011, MVI=1100, LDA=1101, LDI=1110
- op1_reg  in  RADDR_W  destination register
- op2_reg  in  RADDR_W  source register (MOV) or pointer register (LDI)
- busy  out  1  high in every state except IDLE
- rf_rd_addr  out  RADDR_W  register-file read address; combinational read data
- rf_rd_data  in  DATA_W  register-file read data
- fetch_req / fetch_ack / fetch_data  out/in/in  1/1/DATA_W  next-instruction-word fetch
- mem_req / mem_addr / mem_ack / mem_rdata  out/out/in/in  1/DATA_W/1/DATA_W  data-memory read
- wb_valid / wb_ready  out/in  1/1  writeback handshake
- wb_addr  out  RADDR_W  writeback register
- wb_data  out  DATA_W  writeback data
- err  out  1  one-cycle pulse on an illegal opcode

## Operation
- States: IDLE, RDREG, FETCH, MEMRD, WB.
- In IDLE with start=1, opcode, op1_reg and op2_reg are latched. Next state depends on the opcode:
  - MOV: RDREG→WB. rf_rd_addr=op2_reg. wb_addr=op1_reg, wb_data=rf_rd_data.
  - MVI: FETCH→WB. wb_addr=op1_reg, wb_data=fetch_data.
  - LDA: FETCH→MEMRD→WB. mem_addr=fetch_data. wb_addr=ACC_ADDR, wb_data=mem_rdata.
  - LDI: RDREG→MEMRD→WB. mem_addr=rf_rd_data of op2_reg. wb_addr=op1_reg.
  - Any other opcode: err=1 for one cycle, remain in IDLE, no request is issued.
- RDREG lasts exactly one cycle. rf_rd_data is captured at the end of that cycle.
- FETCH: fetch_req is registered high and held until the cycle fetch_ack=1. fetch_data is captured in that cycle and fetch_req drops the next cycle.
- MEMRD: mem_req and mem_addr are held stable until mem_ack=1. mem_rdata is captured in that cycle.
- WB: wb_valid=1. wb_addr and wb_data are stable until wb_ready=1, then the block returns to IDLE.
- Ack inputs asserted without the matching req are ignored. start while busy is ignored and never queued.
- Reset values: all outputs are 0 and the state is IDLE.
- Reset asserted mid-operation aborts immediately: requests drop and the latched operands are discarded.

## Timing
- Start is accepted at edge 0.
- MOV: wb_valid is high from cycle 2.
- MVI: wb_valid is high 1 cycle after the fetch_ack cycle.
- LDA and LDI: wb_valid is high 1 cycle after the mem_ack cycle.
- With zero-wait ack (ack high in the first request cycle):
  - MVI: wb_valid at cycle 2.
  - LDA: wb_valid at cycle 3.
  - LDI: wb_valid at cycle 3.
- Throughput: the WB→IDLE transition costs one bubble, so the next start is accepted at the earliest 1 cycle after the wb handshake.
- err pulses in the cycle after the illegal start is sampled.

## Configuration
- AM_INDIRECT_EN defined: LDI (1110) is legal as specified above.
- AM_INDIRECT_EN undefined: 1110 is treated as illegal (err pulse, no requests). The RDREG→MEMRD path is not built.

## Structure
- Package am_pkg holds:
  - opcode constants OPC_MOV, OPC_MVI, OPC_LDA, OPC_LDI;
  - the state enum am_state_t;
  - the default widths.
- Sub-module addr_mode_decode is combinational. It maps opcode to {legal, needs_rd, needs_fetch, needs_mem, use_acc} and honours AM_INDIRECT_EN.

## Test plan
- MOV: op1=2, op2=5, rf[5]=0xBEEF, wb_ready=1 → wb_valid at cycle 2, wb_addr=2, wb_data=0xBEEF, busy low at cycle 3.
- MVI: op1=4, fetch_ack delayed 3 cycles with fetch_data=0x1234 → fetch_req held 4 cycles, then wb_addr=4, wb_data=0x1234.
- LDA: fetch_data=0x0040, mem[0x0040]=0xA5A5, ACC_ADDR=0 → mem_addr=0x0040 while mem_req is high, then wb_addr=0, wb_data=0xA5A5.
- LDI with AM_INDIRECT_EN: op1=1, op2=3, rf[3]=0x0010, mem[0x0010]=0x0F0F → wb_addr=1, wb_data=0x0F0F. Same stimulus without the macro → err pulse and no mem_req.
- Backpressure and illegal opcode: wb_ready held low for 5 cycles → wb_valid, wb_addr and wb_data stay constant and a second start is ignored. Opcode 0000 → single err pulse and busy stays 0.
- Reset: rst_n pulled low while mem_req=1 → mem_req, busy and wb_valid are 0 immediately. After release the block is in IDLE and a fresh MOV completes normally.

Source files
------------

// File: rtl/am_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the operand sequencer.
package am_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int RADDR_W_DEF  = 3;
    localparam int ACC_ADDR_DEF = 0;

    localparam logic [3:0] OPC_MOV = 4'b1011;
    localparam logic [3:0] OPC_MVI = 4'b1100;
    localparam logic [3:0] OPC_LDA = 4'b1101;
    localparam logic [3:0] OPC_LDI = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RDREG = 3'd1,
        ST_FETCH = 3'd2,
        ST_MEMRD = 3'd3,
        ST_WB    = 3'd4
    } am_state_t;

endpackage

// File: rtl/addr_mode_decode.sv
// Combinational opcode classifier; LDI is only legal when AM_INDIRECT_EN is defined.
module addr_mode_decode
    import am_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       legal,
    output logic       needs_rd,
    output logic       needs_fetch,
    output logic       needs_mem,
    output logic       use_acc
);

    // Map each opcode onto the sequence of operand sources it needs.
    always_comb begin
        legal       = 1'b0;
        needs_rd    = 1'b0;
        needs_fetch = 1'b0;
        needs_mem   = 1'b0;
        use_acc     = 1'b0;
        case (opcode)
            OPC_MOV: begin
                legal    = 1'b1;
                needs_rd = 1'b1;
            end
            OPC_MVI: begin
                legal       = 1'b1;
                needs_fetch = 1'b1;
            end
            OPC_LDA: begin
                legal       = 1'b1;
                needs_fetch = 1'b1;
                needs_mem   = 1'b1;
                use_acc     = 1'b1;
            end
`ifdef AM_INDIRECT_EN
            OPC_LDI: begin
                legal     = 1'b1;
                needs_rd  = 1'b1;
                needs_mem = 1'b1;
            end
`endif
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/addr_mode_seq.sv
// Multi-cycle operand sequencer: register/immediate/direct (and, with AM_INDIRECT_EN,
// register-indirect) operand resolution ending in a single writeback beat.
module addr_mode_seq
    import am_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RADDR_W  = RADDR_W_DEF,
    parameter int ACC_ADDR = ACC_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [3:0]         opcode,
    input  logic [RADDR_W-1:0] op1_reg,
    input  logic [RADDR_W-1:0] op2_reg,
    output logic               busy,
    output logic [RADDR_W-1:0] rf_rd_addr,
    input  logic [DATA_W-1:0]  rf_rd_data,
    output logic               fetch_req,
    input  logic               fetch_ack,
    input  logic [DATA_W-1:0]  fetch_data,
    output logic               mem_req,
    output logic [DATA_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               wb_valid,
    input  logic               wb_ready,
    output logic [RADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]  wb_data,
    output logic               err
);

    am_state_t          state_r;
    logic [3:0]         opcode_r;
    logic [RADDR_W-1:0] op1_r;
    logic [3:0]         dec_opcode_s;
    logic               legal_s;
    logic               needs_rd_s;
    logic               needs_fetch_s;
    logic               needs_mem_s;
    logic               use_acc_s;

    // Classify the incoming opcode while idle, the latched one afterwards.
    always_comb begin
        if (state_r == ST_IDLE) begin
            dec_opcode_s = opcode;
        end else begin
            dec_opcode_s = opcode_r;
        end
    end

    addr_mode_decode u_decode (
        .opcode      (dec_opcode_s),
        .legal       (legal_s),
        .needs_rd    (needs_rd_s),
        .needs_fetch (needs_fetch_s),
        .needs_mem   (needs_mem_s),
        .use_acc     (use_acc_s)
    );

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            opcode_r   <= 4'b0000;
            op1_r      <= '0;
            busy       <= 1'b0;
            rf_rd_addr <= '0;
            fetch_req  <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            wb_valid   <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        opcode_r   <= opcode;
                        op1_r      <= op1_reg;
                        rf_rd_addr <= op2_reg;
                        busy       <= legal_s;
                        if (legal_s && needs_rd_s) begin
                            state_r <= ST_RDREG;
                        end else if (legal_s && needs_fetch_s) begin
                            state_r   <= ST_FETCH;
                            fetch_req <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_RDREG: begin
`ifdef AM_INDIRECT_EN
                    if (needs_mem_s) begin
                        mem_addr <= rf_rd_data;
                        mem_req  <= 1'b1;
                        state_r  <= ST_MEMRD;
                    end else begin
                        wb_addr  <= op1_r;
                        wb_data  <= rf_rd_data;
                        wb_valid <= 1'b1;
                        state_r  <= ST_WB;
                    end
`else
                    wb_addr  <= op1_r;
                    wb_data  <= rf_rd_data;
                    wb_valid <= 1'b1;
                    state_r  <= ST_WB;
`endif
                end
                ST_FETCH: begin
                    if (fetch_ack) begin
                        fetch_req <= 1'b0;
                        if (needs_mem_s) begin
                            mem_addr <= fetch_data;
                            mem_req  <= 1'b1;
                            state_r  <= ST_MEMRD;
                        end else begin
                            wb_addr  <= op1_r;
                            wb_data  <= fetch_data;
                            wb_valid <= 1'b1;
                            state_r  <= ST_WB;
                        end
                    end
                end
                ST_MEMRD: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wb_data  <= mem_rdata;
                        wb_valid <= 1'b1;
                        state_r  <= ST_WB;
                        if (use_acc_s) begin
                            wb_addr <= RADDR_W'(ACC_ADDR);
                        end else begin
                            wb_addr <= op1_r;
                        end
                    end
                end
                ST_WB: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    fetch_req <= 1'b0;
                    mem_req   <= 1'b0;
                    wb_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
